// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with single-line refill from a beat-serial memory port.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | no response pending, ready for a fetch
// S_RESP     | response held on resp_* until the consumer takes it
// S_MISS_REQ | presenting the line refill request to memory
// S_REFILL   | collecting refill beats into the missed line
module icache_dm #(
    parameter int NUM_SETS   = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_data_o,
    output logic [31:0] resp_addr_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_resp_data_i,
    input  logic        flush_i
);

    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(NUM_SETS);
    localparam int TAG_LSB = OFF_W + IDX_W + 2;
    localparam int TAG_W   = 32 - TAG_LSB;

    typedef enum logic [1:0] {S_IDLE, S_RESP, S_MISS_REQ, S_REFILL} state_t;

    state_t                state_q, state_d;
    logic [NUM_SETS-1:0]   valid_q;
    logic [TAG_W-1:0]      tag_q  [NUM_SETS];
    logic [31:0]           data_q [NUM_SETS][LINE_WORDS];
    logic [OFF_W-1:0]      beat_q;
    logic [31:2]           miss_addr_q;
    logic                  flush_seen_q;

    logic [OFF_W-1:0]      req_off, miss_off;
    logic [IDX_W-1:0]      req_idx, miss_idx;
    logic [TAG_W-1:0]      req_tag, miss_tag;
    logic                  hit, accept, beat_in, last_beat;

    assign req_off  = req_addr_i[OFF_W+1:2];
    assign req_idx  = req_addr_i[TAG_LSB-1:OFF_W+2];
    assign req_tag  = req_addr_i[31:TAG_LSB];
    assign miss_off = miss_addr_q[OFF_W+1:2];
    assign miss_idx = miss_addr_q[TAG_LSB-1:OFF_W+2];
    assign miss_tag = miss_addr_q[31:TAG_LSB];

    // A flush in the same cycle forces the lookup to miss.
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !flush_i;
    assign accept    = req_valid_i && req_ready_o;
    assign beat_in   = (state_q == S_REFILL) && mem_resp_valid_i;
    assign last_beat = beat_in && (beat_q == OFF_W'(LINE_WORDS - 1));

    assign mem_req_addr_o = {miss_addr_q[31:OFF_W+2], {(OFF_W + 2){1'b0}}};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d         = state_q;
        req_ready_o     = (state_q == S_IDLE) || ((state_q == S_RESP) && resp_ready_i);
        resp_valid_o    = (state_q == S_RESP);
        mem_req_valid_o = (state_q == S_MISS_REQ);
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = hit ? S_RESP : S_MISS_REQ;
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    if (accept) state_d = hit ? S_RESP : S_MISS_REQ;
                    else        state_d = S_IDLE;
                end
            end
            S_MISS_REQ: begin
                if (mem_req_ready_i) state_d = S_REFILL;
            end
            S_REFILL: begin
                if (last_beat) state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Valid bits, miss bookkeeping and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= '0;
            beat_q       <= '0;
            miss_addr_q  <= '0;
            flush_seen_q <= 1'b0;
            resp_data_o  <= '0;
            resp_addr_o  <= '0;
        end else begin
            if (accept) begin
                resp_addr_o <= req_addr_i;
                if (hit) begin
                    resp_data_o <= data_q[req_idx][req_off];
                end else begin
                    miss_addr_q      <= req_addr_i[31:2];
                    valid_q[req_idx] <= 1'b0;
                    flush_seen_q     <= 1'b0;
                end
            end
            if ((state_q == S_MISS_REQ) && mem_req_ready_i) beat_q <= '0;
            if (beat_in) begin
                beat_q <= beat_q + OFF_W'(1);
                if (beat_q == miss_off) resp_data_o <= mem_resp_data_i;
                if (last_beat && !flush_seen_q && !flush_i) valid_q[miss_idx] <= 1'b1;
            end
            if (flush_i && ((state_q == S_MISS_REQ) || (state_q == S_REFILL)))
                flush_seen_q <= 1'b1;
            // Flush wins over any per-line valid update in the same cycle.
            if (flush_i) valid_q <= '0;
        end
    end

    // Line data and tag; guarded by valid_q, so no reset needed.
    always_ff @(posedge clk) begin
        if (beat_in) begin
            data_q[miss_idx][beat_q] <= mem_resp_data_i;
            if (last_beat) tag_q[miss_idx] <= miss_tag;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Randomized self-checking bench for icache_dm against a line-level reference model.
module tb_icache_dm;

    localparam int NS = 16;
    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i, req_ready_o;
    logic [31:0] req_addr_i;
    logic        resp_valid_o, resp_ready_i;
    logic [31:0] resp_data_o, resp_addr_o;
    logic        mem_req_valid_o, mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_resp_valid_i;
    logic [31:0] mem_resp_data_i;
    logic        flush_i;

    int checks   = 0;
    int failures = 0;

    // Reference model: which lines hold which tag.
    logic [NS-1:0] mv;
    logic [23:0]   mt [NS];

    icache_dm #(.NUM_SETS(NS), .LINE_WORDS(LW)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_data_o(resp_data_o), .resp_addr_o(resp_addr_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i),
        .flush_i(flush_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Backing memory contents; the first line carries the directed values.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a[31:4] == 28'h8000000) return 32'h11 * (int'(a[3:2]) + 1);
        return a ^ 32'hDEADBEEF;
    endfunction

    // Serve refill beats with random gaps; optional flush on the second valid beat.
    task automatic serve_beats(input logic [31:0] line, input int first, input int last,
                               input bit fl, output bit flushed);
        int b;
        b = first;
        flushed = 1'b0;
        while (b <= last) begin
            if ($urandom_range(0, 3) == 0) begin
                mem_resp_valid_i = 1'b0;
                mem_resp_data_i  = $urandom;
                flush_i          = 1'b0;
            end else begin
                mem_resp_valid_i = 1'b1;
                mem_resp_data_i  = mem_data(line + 32'(b * 4));
                flush_i          = fl && (b == 1);
                if (flush_i) flushed = 1'b1;
                b++;
            end
            step();
        end
        mem_resp_valid_i = 1'b0;
        flush_i          = 1'b0;
    endtask

    task automatic do_req(input logic [31:0] a, input bit fl, input int hold);
        int  n, idx;
        bit  missed, exp_miss, flushed, fl_seen;
        logic [31:0] line;
        idx      = int'(a[7:4]);
        line     = {a[31:4], 4'h0};
        exp_miss = !(mv[idx] && (mt[idx] == a[31:8]));
        fl_seen  = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = a;
        n = 0;
        while (!req_ready_o && n < 50) begin step(); n++; end
        step();
        req_valid_i = 1'b0;
        missed = 1'b0;
        n = 0;
        while (!resp_valid_o && n < 100) begin
            if (mem_req_valid_o) begin
                missed = 1'b1;
                chk("mem_req_addr", mem_req_addr_o, line);
                repeat ($urandom_range(0, 2)) step();
                mem_req_ready_i = 1'b1;
                step();
                mem_req_ready_i = 1'b0;
                chk("mem_req_drop", mem_req_valid_o, 0);
                serve_beats(line, 0, LW - 1, fl, flushed);
                fl_seen = flushed;
            end else begin
                step();
            end
            n++;
        end
        chk("resp_valid", resp_valid_o, 1);
        chk("miss", missed, exp_miss);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid", resp_valid_o, 1);
            chk("hold_ready", req_ready_o, 0);
        end
        chk("resp_data", resp_data_o, mem_data({a[31:2], 2'b00}));
        chk("resp_addr", resp_addr_o, a);
        resp_ready_i = 1'b1;
        step();
        resp_ready_i = 1'b0;
        if (fl_seen) mv = '0;
        else if (missed) begin
            mv[idx] = 1'b1;
            mt[idx] = a[31:8];
        end
    endtask

    initial begin
        logic [31:0] hs_addr [3];
        logic [31:0] ra;
        bit          dummy;
        reset = 1'b1;
        req_valid_i = 0; req_addr_i = 0; resp_ready_i = 0;
        mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_resp_data_i = 0; flush_i = 0;
        mv = '0;
        for (int i = 0; i < NS; i++) mt[i] = '0;
        step();
        step();
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_mem_req_valid", mem_req_valid_o, 0);
        chk("rst_resp_data", resp_data_o, 0);
        chk("rst_resp_addr", resp_addr_o, 0);
        chk("rst_mem_req_addr", mem_req_addr_o, 0);
        reset = 1'b0;
        step();

        // Cold miss, then a hit stream from the same line.
        do_req(32'h80000008, 1'b0, 0);
        hs_addr[0] = 32'h80000000;
        hs_addr[1] = 32'h80000004;
        hs_addr[2] = 32'h8000000C;
        resp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid_i = 1'b1;
            req_addr_i  = hs_addr[i];
            step();
            chk("stream_valid", resp_valid_o, 1);
            chk("stream_data", resp_data_o, 32'h11 * (i == 2 ? 4 : i + 1));
            chk("stream_addr", resp_addr_o, hs_addr[i]);
            chk("stream_no_mem", mem_req_valid_o, 0);
        end
        req_valid_i = 1'b0;
        step();
        resp_ready_i = 1'b0;
        chk("stream_idle", resp_valid_o, 0);

        // Backpressure on a hit.
        do_req(32'h80000004, 1'b0, 5);

        // Conflict on index 0.
        do_req(32'h80000100, 1'b0, 0);
        do_req(32'h80000000, 1'b0, 0);

        // Flush during refill: response still delivered, line stays invalid.
        do_req(32'h80000050, 1'b1, 0);
        do_req(32'h80000050, 1'b0, 0);

        // Reset during refill after two beats.
        req_valid_i = 1'b1;
        req_addr_i  = 32'h80000060;
        step();
        req_valid_i = 1'b0;
        chk("rr_mem_req", mem_req_valid_o, 1);
        mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0;
        serve_beats(32'h80000060, 0, 1, 1'b0, dummy);
        reset = 1'b1;
        #1;
        chk("rr_async_ready", req_ready_o, 1);
        chk("rr_async_mem_req", mem_req_valid_o, 0);
        step();
        reset = 1'b0;
        mv = '0;
        for (int b = 2; b < LW; b++) begin
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = 32'hBAD0_0000 + 32'(b);
            step();
            chk("rr_no_resp", resp_valid_o, 0);
            chk("rr_no_mem_req", mem_req_valid_o, 0);
        end
        mem_resp_valid_i = 1'b0;
        step();
        do_req(32'h80000060, 1'b0, 0);
        do_req(32'h80000004, 1'b0, 0);

        // Randomized traffic with occasional flushes and backpressure.
        for (int i = 0; i < 80; i++) begin
            ra = 32'h80000000
               | (32'($urandom_range(0, 3)) << 8)
               | (32'($urandom_range(0, NS - 1)) << 4)
               | (32'($urandom_range(0, LW - 1)) << 2)
               | 32'($urandom_range(0, 3));
            do_req(ra, $urandom_range(0, 9) == 0, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
